// File: rtl/pos_data_distributor_seq.sv
// Home-cell position reader: sweeps every home particle once per phase, absorbs back pressure in a 2-entry skid buffer.
// Build macro PDD_EMPTY_SLOT_FILTER_EN: all-zero RAM records are treated as empty slots and carry no pair flags.
module pos_data_distributor_seq #(
  parameter int OFFSET_WIDTH                      = 29,
  parameter int CELL_ID_WIDTH                     = 3,
  parameter int DATA_WIDTH                        = OFFSET_WIDTH + CELL_ID_WIDTH,
  parameter logic [CELL_ID_WIDTH-1:0] HOME_CELL_ID = 3'b010,
  parameter int NUM_NEIGHBOR_CELLS                = 13,
  parameter int NUM_FILTER                        = 7,
  parameter int NUM_PHASES                        = 2,
  parameter int PARTICLE_ID_WIDTH                 = 7
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              start,
  input  logic [PARTICLE_ID_WIDTH:0]                        num_particles,
  output logic                                              rd_en,
  output logic [PARTICLE_ID_WIDTH-1:0]                      rd_addr,
  input  logic [3*OFFSET_WIDTH-1:0]                         rd_nb_position,
  input  logic [NUM_NEIGHBOR_CELLS:0]                       broadcast_done,
  input  logic                                              ref_not_read_yet,
  input  logic [NUM_FILTER-1:0]                             ref_valid,
  input  logic                                              pause_reading,
  output logic                                              out_valid,
  output logic [3*DATA_WIDTH-1:0]                           assembled_position,
  output logic [NUM_FILTER-1:0]                             pair_valid,
  output logic [PARTICLE_ID_WIDTH-1:0]                      out_particle_id,
  output logic [((NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1)-1:0] out_phase,
  output logic                                              busy,
  output logic                                              done
);

  localparam int PHW  = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam int PIW  = PARTICLE_ID_WIDTH;
  localparam int POSW = 3*DATA_WIDTH;
  localparam int ENTW = POSW + NUM_FILTER + PIW + PHW;
  localparam logic [PHW-1:0] LAST_PHASE = PHW'(NUM_PHASES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Slot s = phase*NUM_FILTER+f; slots past the last neighbour cell never pair, home slot skips self-pair.
  function automatic logic [NUM_FILTER-1:0] calc_pair_valid(
    input logic [PHW-1:0]              phase,
    input logic [NUM_NEIGHBOR_CELLS:0] bd,
    input logic [NUM_FILTER-1:0]       rv,
    input logic                        ref_pending
  );
    logic [NUM_FILTER-1:0]       flags;
    logic [NUM_NEIGHBOR_CELLS:0] bd_sh;
    int                          slot;
    flags = '0;
    for (int f = 0; f < NUM_FILTER; f++) begin
      slot  = int'(phase) * NUM_FILTER + f;
      bd_sh = bd >> slot;
      if (slot <= NUM_NEIGHBOR_CELLS) flags[f] = ~bd_sh[0] & rv[f];
      else                            flags[f] = 1'b0;
    end
    if (phase == PHW'(0)) flags[0] = flags[0] & ~ref_pending;
    else                  flags[0] = flags[0];
    return flags;
  endfunction

  logic [1:0]            r_state;
  logic [PIW-1:0]        r_addr;
  logic [PIW-1:0]        r_last_addr;
  logic [PHW-1:0]        r_phase;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_inflight;
  logic [PIW-1:0]        r_fl_id;
  logic [PHW-1:0]        r_fl_phase;
  logic [ENTW-1:0]       r_out;
  logic                  r_out_valid;
  logic [ENTW-1:0]       r_skid0;
  logic [ENTW-1:0]       r_skid1;
  logic [1:0]            r_skid_cnt;

  logic [1:0]            w_occ;
  logic                  w_rd;
  logic                  w_xfer;
  logic                  w_to_out;
  logic                  w_push;
  logic                  w_pop;
  logic [POSW-1:0]       w_pos;
  logic [NUM_FILTER-1:0] w_flags_raw;
  logic [NUM_FILTER-1:0] w_flags;
  logic [ENTW-1:0]       w_new;

  // Two credits shared between skid slots and the read in flight.
  assign w_occ    = r_skid_cnt + {1'b0, r_inflight};
  assign w_rd     = (r_state == ST_READ) && (w_occ < 2'd2);
  assign w_xfer   = r_out_valid & ~pause_reading;
  assign w_to_out = r_inflight && (!r_out_valid || w_xfer) && (r_skid_cnt == 2'd0);
  assign w_push   = r_inflight && !w_to_out;
  assign w_pop    = w_xfer && (r_skid_cnt != 2'd0);

  assign w_pos = {HOME_CELL_ID, rd_nb_position[3*OFFSET_WIDTH-1 -: OFFSET_WIDTH],
                  HOME_CELL_ID, rd_nb_position[2*OFFSET_WIDTH-1 -: OFFSET_WIDTH],
                  HOME_CELL_ID, rd_nb_position[OFFSET_WIDTH-1:0]};
  assign w_flags_raw = calc_pair_valid(r_fl_phase, broadcast_done, ref_valid, ref_not_read_yet);

  // Final pair flags for the record returning this cycle.
  always_comb begin
`ifdef PDD_EMPTY_SLOT_FILTER_EN
    if (rd_nb_position == {(3*OFFSET_WIDTH){1'b0}}) w_flags = {NUM_FILTER{1'b0}};
    else                                             w_flags = w_flags_raw;
`else
    w_flags = w_flags_raw;
`endif
  end

  assign w_new = {w_pos, w_flags, r_fl_id, r_fl_phase};

  // Sweep sequencer: address/phase counters, busy and done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= PIW'(0);
      r_last_addr <= PIW'(0);
      r_phase     <= PHW'(0);
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (num_particles == (PIW+1)'(0)) begin
              r_done <= 1'b1;
            end else begin
              r_state     <= ST_READ;
              r_busy      <= 1'b1;
              r_addr      <= PIW'(0);
              r_phase     <= PHW'(0);
              r_last_addr <= num_particles[PIW-1:0] - PIW'(1);
            end
          end
        end
        ST_READ: begin
          if (w_rd) begin
            if (r_addr == r_last_addr) begin
              r_addr <= PIW'(0);
              if (r_phase == LAST_PHASE) r_state <= ST_DRAIN;
              else                       r_phase <= r_phase + PHW'(1);
            end else begin
              r_addr <= r_addr + PIW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_xfer && (r_skid_cnt == 2'd0) && !r_inflight) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Tag of the read in flight, so the returning record knows its address and phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_fl_id    <= PIW'(0);
      r_fl_phase <= PHW'(0);
    end else begin
      r_inflight <= w_rd;
      r_fl_id    <= r_addr;
      r_fl_phase <= r_phase;
    end
  end

  // Output register and skid buffer: returns always land; a transfer reloads from the skid head first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= ENTW'(0);
      r_out_valid <= 1'b0;
      r_skid0     <= ENTW'(0);
      r_skid1     <= ENTW'(0);
      r_skid_cnt  <= 2'd0;
    end else begin
      if (w_to_out) begin
        r_out       <= w_new;
        r_out_valid <= 1'b1;
      end else if (w_pop) begin
        r_out       <= r_skid0;
        r_out_valid <= 1'b1;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10: begin
          if (r_skid_cnt == 2'd0) r_skid0 <= w_new;
          else                    r_skid1 <= w_new;
          r_skid_cnt <= r_skid_cnt + 2'd1;
        end
        2'b01: begin
          r_skid0    <= r_skid1;
          r_skid_cnt <= r_skid_cnt - 2'd1;
        end
        2'b11: begin
          if (r_skid_cnt == 2'd1) begin
            r_skid0 <= w_new;
          end else begin
            r_skid0 <= r_skid1;
            r_skid1 <= w_new;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_en              = w_rd;
  assign rd_addr            = r_addr;
  assign out_valid          = r_out_valid;
  assign assembled_position = r_out[ENTW-1 -: POSW];
  assign pair_valid         = r_out[PHW+PIW +: NUM_FILTER];
  assign out_particle_id    = r_out[PHW +: PIW];
  assign out_phase          = r_out[PHW-1:0];
  assign busy               = r_busy;
  assign done               = r_done;

endmodule

// File: tb/tb_pos_data_distributor_seq.sv
// Self-checking bench for pos_data_distributor_seq: RAM responder plus a queue-based expected-transfer model.
module tb_pos_data_distributor_seq;

  localparam int NP  = 2;
  localparam int NF  = 7;
  localparam int NNC = 13;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num_particles;
  logic        rd_en;
  logic [6:0]  rd_addr;
  logic [86:0] rd_nb_position;
  logic [13:0] broadcast_done;
  logic        ref_not_read_yet;
  logic [6:0]  ref_valid;
  logic        pause_reading;
  logic        out_valid;
  logic [95:0] assembled_position;
  logic [6:0]  pair_valid;
  logic [6:0]  out_particle_id;
  logic [0:0]  out_phase;
  logic        busy;
  logic        done;

  logic [86:0] mem [0:127];
  int n_evals = 0;
  int n_fails = 0;

  typedef struct {
    logic [6:0]  id;
    logic        ph;
    logic [95:0] pos;
    logic [6:0]  flags;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pos_data_distributor_seq dut (
    .clk(clk), .rst(rst), .start(start), .num_particles(num_particles),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_nb_position(rd_nb_position),
    .broadcast_done(broadcast_done), .ref_not_read_yet(ref_not_read_yet),
    .ref_valid(ref_valid), .pause_reading(pause_reading), .out_valid(out_valid),
    .assembled_position(assembled_position), .pair_valid(pair_valid),
    .out_particle_id(out_particle_id), .out_phase(out_phase), .busy(busy), .done(done)
  );

  // Position RAM: one-cycle read latency, junk on the bus when no read was issued.
  always @(posedge clk) begin : ram_model
    logic [95:0] junk;
    junk = {$urandom, $urandom, $urandom};
    if (rd_en) rd_nb_position <= mem[rd_addr];
    else       rd_nb_position <= junk[86:0];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_evals++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] model_pos(input logic [86:0] raw);
    return {3'b010, raw[86:58], 3'b010, raw[57:29], 3'b010, raw[28:0]};
  endfunction

  function automatic logic [6:0] model_flags(input int ph, input logic [13:0] bd, input logic [6:0] rv,
                                             input logic rnry, input logic [86:0] raw);
    logic [6:0] r;
    int slot;
    r = 7'h00;
    for (int f = 0; f < NF; f++) begin
      slot = ph * NF + f;
      if (slot <= NNC) r[f] = rv[f] & ~bd[slot] & ~((slot == 0) & rnry);
    end
`ifdef PDD_EMPTY_SLOT_FILTER_EN
    if (raw == 87'd0) r = 7'h00;
`endif
    return r;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, ":rd_en"},     rd_en, 1'b0);
    check({tag, ":rd_addr"},   rd_addr, 7'd0);
    check({tag, ":out_valid"}, out_valid, 1'b0);
    check({tag, ":pair_valid"}, pair_valid, 7'd0);
    check({tag, ":position"},  assembled_position, 96'd0);
    check({tag, ":out_id"},    out_particle_id, 7'd0);
    check({tag, ":out_phase"}, out_phase, 1'b0);
    check({tag, ":busy"},      busy, 1'b0);
    check({tag, ":done"},      done, 1'b0);
  endtask

  task automatic run_sweep(input int n, input logic [13:0] bd, input logic [6:0] rv, input logic rnry,
                           input int p_at, input int p_len, input bit chk_bubble, input int restart_at,
                           input string tag);
    int   cyc, reads, dones, done_cyc, first_ov, stall_reads, extras, limit;
    bit   in_pause;
    exp_t e;
    exp_q.delete();
    for (int ph = 0; ph < NP; ph++) begin
      for (int a = 0; a < n; a++) begin
        e.id    = a[6:0];
        e.ph    = ph[0];
        e.pos   = model_pos(mem[a]);
        e.flags = model_flags(ph, bd, rv, rnry, mem[a]);
        exp_q.push_back(e);
      end
    end
    cyc = 0; reads = 0; dones = 0; done_cyc = -1; first_ov = -1; stall_reads = 0; extras = 0;
    limit = NP * n + p_len + 30;
    @(negedge clk);
    broadcast_done   = bd;
    ref_valid        = rv;
    ref_not_read_yet = rnry;
    num_particles    = n[7:0];
    start            = 1'b1;
    while (dones == 0 && cyc < limit) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_at);
      if (cyc == 1) num_particles = 8'($urandom_range(1, 127));
      in_pause      = (p_len > 0) && (cyc >= p_at) && (cyc < p_at + p_len);
      pause_reading = in_pause;
      #1;
      if (cyc == 1) begin
        check({tag, ":busy_t+1"},  busy, n > 0);
        check({tag, ":rd_en_t+1"}, rd_en, n > 0);
      end
      if (rd_en) reads++;
      if (rd_en && in_pause && out_valid) stall_reads++;
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (chk_bubble && (cyc == p_at + p_len || cyc == p_at + p_len + 1))
        check({tag, ":no_bubble"}, out_valid, 1'b1);
      if (out_valid && !pause_reading) begin
        if (exp_q.size() == 0) begin
          extras++;
        end else begin
          e = exp_q.pop_front();
          check({tag, ":id"},    out_particle_id, e.id);
          check({tag, ":phase"}, out_phase, e.ph);
          check({tag, ":pos"},   assembled_position, e.pos);
          check({tag, ":flags"}, pair_valid, e.flags);
        end
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        check({tag, ":busy_at_done"}, busy, 1'b0);
      end
    end
    start         = 1'b0;
    pause_reading = 1'b0;
    check({tag, ":done_count"},     dones, 1);
    check({tag, ":extra_transfers"}, extras, 0);
    check({tag, ":remaining"},      exp_q.size(), 0);
    check({tag, ":read_count"},     reads, NP * n);
    check({tag, ":stall_reads_le2"}, stall_reads <= 2, 1'b1);
    if (n == 0) check({tag, ":done_latency"}, done_cyc, 1);
    else if (p_len == 0) begin
      check({tag, ":done_latency"},  done_cyc, NP * n + 3);
      check({tag, ":first_out_lat"}, first_ov, 3);
    end
  endtask

  initial begin
    logic [95:0] tmp;
    for (int i = 0; i < 128; i++) begin
      tmp    = {$urandom, $urandom, $urandom};
      mem[i] = tmp[86:0];
    end
    rst = 1'b1; start = 1'b0; num_particles = 8'd0; broadcast_done = 14'd0;
    ref_not_read_yet = 1'b1; ref_valid = 7'h7F; pause_reading = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    run_sweep(3, 14'h0000, 7'h7F, 1'b1, 0, 0, 1'b0, -1, "tp_basic");
    run_sweep(3, 14'h0081, 7'h7F, 1'b1, 0, 0, 1'b0, -1, "tp_bdone");
    run_sweep(10, 14'($urandom), 7'($urandom), 1'($urandom), 6, 5, 1'b1, 4, "tp_pause");
    run_sweep(0, 14'h0000, 7'h7F, 1'b0, 0, 0, 1'b0, -1, "tp_zero");

    // Reset while a read is in flight.
    @(negedge clk);
    num_particles = 8'd5;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_mid:rd_en_before", rd_en, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset("rst_mid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("rst_mid:no_out", out_valid, 1'b0);
      check("rst_mid:no_done", done, 1'b0);
    end
    run_sweep(4, 14'h0000, 7'h7F, 1'b0, 0, 0, 1'b0, -1, "after_rst");

    mem[1] = 87'd0;
    run_sweep(4, 14'($urandom), 7'h7F, 1'b0, 0, 0, 1'b0, -1, "zero_rec");

    for (int k = 0; k < 4; k++)
      run_sweep($urandom_range(1, 20), 14'($urandom), 7'($urandom), 1'($urandom),
                $urandom_range(2, 10), $urandom_range(0, 6), 1'b0, -1, "random");

    run_sweep(128, 14'($urandom), 7'($urandom), 1'b1, 0, 0, 1'b0, -1, "full");

    $display("End of test - %0d assertions evaluated, %0d failures", n_evals, n_fails);
    $finish;
  end

endmodule
